// File: rtl/add_rs_if.sv
`default_nettype none
// ============================================================================
// add_rs_if : issue / CDB / dispatch bundle for the add/sub reservation station
// Rev 1.0
// ============================================================================
interface add_rs_if;
    logic        issue_valid;
    logic        issue_isadd;
    logic [31:0] issue_vj;
    logic [31:0] issue_vk;
    logic [3:0]  issue_qj;
    logic [3:0]  issue_qk;
    logic        issue_ready;
    logic [3:0]  issue_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        exe_start;
    logic [31:0] exe_srca;
    logic [31:0] exe_srcb;
    logic        exe_isadd;
    logic [3:0]  exe_tag;

    modport master (
        output issue_valid, issue_isadd, issue_vj, issue_vk, issue_qj, issue_qk,
        output cdb_valid, cdb_tag, cdb_data,
        input  issue_ready, issue_tag,
        input  exe_start, exe_srca, exe_srcb, exe_isadd, exe_tag
    );

    modport slave (
        input  issue_valid, issue_isadd, issue_vj, issue_vk, issue_qj, issue_qk,
        input  cdb_valid, cdb_tag, cdb_data,
        output issue_ready, issue_tag,
        output exe_start, exe_srca, exe_srcb, exe_isadd, exe_tag
    );
endinterface
`default_nettype wire

// File: rtl/add_rs.sv
`default_nettype none
// ============================================================================
// add_rs : Tomasulo add/sub reservation station feeding a single adder
// Rev 1.0
// ============================================================================
module add_rs #(
    parameter int NUM_ENTRIES = 3,
    parameter int TAG_BASE    = 1
) (
    input  wire logic  clk,
    input  wire logic  reset,
    add_rs_if.slave    rs_if
);
    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } state_t;

    state_t      state_q [NUM_ENTRIES];
    state_t      state_d [NUM_ENTRIES];
    logic        isadd_q [NUM_ENTRIES];
    logic        isadd_d [NUM_ENTRIES];
    logic [31:0] vj_q    [NUM_ENTRIES];
    logic [31:0] vj_d    [NUM_ENTRIES];
    logic [31:0] vk_q    [NUM_ENTRIES];
    logic [31:0] vk_d    [NUM_ENTRIES];
    logic [3:0]  qj_q    [NUM_ENTRIES];
    logic [3:0]  qj_d    [NUM_ENTRIES];
    logic [3:0]  qk_q    [NUM_ENTRIES];
    logic [3:0]  qk_d    [NUM_ENTRIES];

    logic        unit_busy_q, unit_busy_d;
    logic        exe_start_q, exe_start_d;
    logic [31:0] exe_srca_q,  exe_srca_d;
    logic [31:0] exe_srcb_q,  exe_srcb_d;
    logic        exe_isadd_q, exe_isadd_d;
    logic [3:0]  exe_tag_q,   exe_tag_d;

    logic        free_found, ready_found;
    int          free_idx,   ready_idx;
    logic        sel_isadd;
    logic [31:0] sel_vj, sel_vk;
    logic [3:0]  sel_tag;
    logic        cdb_hit, issue_accept, dispatch;

    // Tag 0 means "no producer", so a broadcast on tag 0 can never wake anything.
    assign cdb_hit      = rs_if.cdb_valid && (rs_if.cdb_tag != 4'd0);
    assign issue_accept = rs_if.issue_valid && free_found;
    assign dispatch     = !unit_busy_q && ready_found;

    // Downward scan leaves the lowest-index match in place.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = 0;
        ready_found = 1'b0;
        ready_idx   = 0;
        sel_isadd   = 1'b0;
        sel_vj      = 32'd0;
        sel_vk      = 32'd0;
        sel_tag     = 4'd0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = i;
            end
            if (state_q[i] == ST_READY) begin
                ready_found = 1'b1;
                ready_idx   = i;
                sel_isadd   = isadd_q[i];
                sel_vj      = vj_q[i];
                sel_vk      = vk_q[i];
                sel_tag     = 4'(TAG_BASE + i);
            end
        end
    end

    assign rs_if.issue_ready = free_found;
    assign rs_if.issue_tag   = free_found ? 4'(TAG_BASE + free_idx) : 4'd0;

    always_comb begin
        state_d = state_q;
        isadd_d = isadd_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            case (state_q[i])
                ST_FREE: begin
                    if (issue_accept && (free_idx == i)) begin
                        isadd_d[i] = rs_if.issue_isadd;
                        vj_d[i]    = rs_if.issue_vj;
                        qj_d[i]    = rs_if.issue_qj;
                        vk_d[i]    = rs_if.issue_vk;
                        qk_d[i]    = rs_if.issue_qk;
                        // Same-cycle bypass from a broadcast of the awaited producer.
                        if (cdb_hit && (rs_if.issue_qj == rs_if.cdb_tag)) begin
                            vj_d[i] = rs_if.cdb_data;
                            qj_d[i] = 4'd0;
                        end
                        if (cdb_hit && (rs_if.issue_qk == rs_if.cdb_tag)) begin
                            vk_d[i] = rs_if.cdb_data;
                            qk_d[i] = 4'd0;
                        end
                        state_d[i] = ((qj_d[i] == 4'd0) && (qk_d[i] == 4'd0)) ? ST_READY : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cdb_hit && (qj_q[i] == rs_if.cdb_tag)) begin
                        vj_d[i] = rs_if.cdb_data;
                        qj_d[i] = 4'd0;
                    end
                    if (cdb_hit && (qk_q[i] == rs_if.cdb_tag)) begin
                        vk_d[i] = rs_if.cdb_data;
                        qk_d[i] = 4'd0;
                    end
                    if ((qj_d[i] == 4'd0) && (qk_d[i] == 4'd0)) begin
                        state_d[i] = ST_READY;
                    end
                end
                ST_READY: begin
                    if (dispatch && (ready_idx == i)) begin
                        state_d[i] = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cdb_hit && (rs_if.cdb_tag == 4'(TAG_BASE + i))) begin
                        state_d[i] = ST_FREE;
                    end
                end
                default: state_d[i] = ST_FREE;
            endcase
        end
    end

    // Dispatch is gated by the registered busy flag, so a completion and the
    // next dispatch can never share an edge.
    always_comb begin
        unit_busy_d = unit_busy_q;
        exe_start_d = dispatch;
        exe_srca_d  = exe_srca_q;
        exe_srcb_d  = exe_srcb_q;
        exe_isadd_d = exe_isadd_q;
        exe_tag_d   = exe_tag_q;
        if (dispatch) begin
            unit_busy_d = 1'b1;
            exe_srca_d  = sel_vj;
            exe_srcb_d  = sel_vk;
            exe_isadd_d = sel_isadd;
            exe_tag_d   = sel_tag;
        end else if (unit_busy_q && cdb_hit && (rs_if.cdb_tag == exe_tag_q)) begin
            unit_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= ST_FREE;
                isadd_q[i] <= 1'b0;
                vj_q[i]    <= 32'd0;
                vk_q[i]    <= 32'd0;
                qj_q[i]    <= 4'd0;
                qk_q[i]    <= 4'd0;
            end
            unit_busy_q <= 1'b0;
            exe_start_q <= 1'b0;
            exe_srca_q  <= 32'd0;
            exe_srcb_q  <= 32'd0;
            exe_isadd_q <= 1'b0;
            exe_tag_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            isadd_q     <= isadd_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            unit_busy_q <= unit_busy_d;
            exe_start_q <= exe_start_d;
            exe_srca_q  <= exe_srca_d;
            exe_srcb_q  <= exe_srcb_d;
            exe_isadd_q <= exe_isadd_d;
            exe_tag_q   <= exe_tag_d;
        end
    end

    assign rs_if.exe_start = exe_start_q;
    assign rs_if.exe_srca  = exe_srca_q;
    assign rs_if.exe_srcb  = exe_srcb_q;
    assign rs_if.exe_isadd = exe_isadd_q;
    assign rs_if.exe_tag   = exe_tag_q;
endmodule
`default_nettype wire

// File: tb/tb_add_rs.sv
`default_nettype none
// ============================================================================
// tb_add_rs : directed vector table plus hand sequences for add_rs
// Rev 1.0
// ============================================================================
module tb_add_rs;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    add_rs_if bus ();

    add_rs #(.NUM_ENTRIES(3), .TAG_BASE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .rs_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        isadd;
        logic [31:0] vj;
        logic [3:0]  qj;
        logic [31:0] vk;
        logic [3:0]  qk;
        logic        byp_valid;
        logic [3:0]  byp_tag;
        logic [31:0] byp_data;
        logic [3:0]  wake_tag;
        logic [31:0] wake_data;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 1'b0;
        bus.issue_isadd = 1'b0;
        bus.issue_vj    = 32'd0;
        bus.issue_vk    = 32'd0;
        bus.issue_qj    = 4'd0;
        bus.issue_qk    = 4'd0;
        bus.cdb_valid   = 1'b0;
        bus.cdb_tag     = 4'd0;
        bus.cdb_data    = 32'd0;
    endtask

    task automatic issue(input logic isadd, input logic [31:0] vj, input logic [3:0] qj,
                         input logic [31:0] vk, input logic [3:0] qk);
        bus.issue_valid = 1'b1;
        bus.issue_isadd = isadd;
        bus.issue_vj    = vj;
        bus.issue_qj    = qj;
        bus.issue_vk    = vk;
        bus.issue_qk    = qk;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    initial begin
        logic seen;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idle_inputs();

        //            isadd vj            qj    vk        qk    bv    bt    bd           wt    wd            a             b
        vecs[0] = '{1'b1, 32'd5,        4'd0, 32'd7,    4'd0, 1'b0, 4'd0, 32'd0,       4'd0, 32'd0,        32'd5,        32'd7};
        vecs[1] = '{1'b0, 32'd0,        4'd4, 32'd3,    4'd0, 1'b0, 4'd0, 32'd0,       4'd4, 32'd10,       32'd10,       32'd3};
        vecs[2] = '{1'b1, 32'd1,        4'd0, 32'd0,    4'd5, 1'b1, 4'd5, 32'h20,      4'd0, 32'd0,        32'd1,        32'h20};
        vecs[3] = '{1'b0, 32'd0,        4'd6, 32'd0,    4'd6, 1'b0, 4'd0, 32'd0,       4'd6, 32'h55,       32'h55,       32'h55};
        vecs[4] = '{1'b1, 32'hFFFFFFFF, 4'd0, 32'd0,    4'd8, 1'b1, 4'd9, 32'h999,     4'd8, 32'h1234,     32'hFFFFFFFF, 32'h1234};

        #12;
        chk("rst_ready",  32'(bus.issue_ready), 32'd1);
        chk("rst_tag",    32'(bus.issue_tag),   32'd1);
        chk("rst_start",  32'(bus.exe_start),   32'd0);
        chk("rst_srca",   bus.exe_srca,         32'd0);
        chk("rst_exetag", 32'(bus.exe_tag),     32'd0);
        reset = 1'b1;
        tick();

        for (int r = 0; r < NV; r++) begin
            chk("vec_idle_ready", 32'(bus.issue_ready), 32'd1);
            chk("vec_idle_tag",   32'(bus.issue_tag),   32'd1);
            issue(vecs[r].isadd, vecs[r].vj, vecs[r].qj, vecs[r].vk, vecs[r].qk);
            if (vecs[r].byp_valid) cdb(vecs[r].byp_tag, vecs[r].byp_data);
            tick();
            idle_inputs();
            if (vecs[r].wake_tag != 4'd0) begin
                tick();
                chk("vec_wait_nostart", 32'(bus.exe_start), 32'd0);
                cdb(vecs[r].wake_tag, vecs[r].wake_data);
                tick();
                idle_inputs();
                chk("vec_wake_nostart", 32'(bus.exe_start), 32'd0);
            end
            tick();
            chk("vec_start", 32'(bus.exe_start), 32'd1);
            chk("vec_srca",  bus.exe_srca,        vecs[r].exp_a);
            chk("vec_srcb",  bus.exe_srcb,        vecs[r].exp_b);
            chk("vec_isadd", 32'(bus.exe_isadd),  32'(vecs[r].isadd));
            chk("vec_etag",  32'(bus.exe_tag),    32'd1);
            tick();
            chk("vec_pulse_end", 32'(bus.exe_start), 32'd0);
            cdb(4'd1, 32'h0);
            tick();
            idle_inputs();
            chk("vec_done_ready", 32'(bus.issue_ready), 32'd1);
            chk("vec_hold_srca",  bus.exe_srca,          vecs[r].exp_a);
        end

        // Fill all three entries, then try a fourth while full.
        issue(1'b1, 32'd1, 4'd0, 32'd2, 4'd0);
        tick();
        issue(1'b1, 32'd3, 4'd0, 32'd4, 4'd0);
        tick();
        chk("fill_d1_start", 32'(bus.exe_start), 32'd1);
        chk("fill_d1_tag",   32'(bus.exe_tag),   32'd1);
        issue(1'b0, 32'd5, 4'd0, 32'd6, 4'd0);
        tick();
        chk("full_ready", 32'(bus.issue_ready), 32'd0);
        chk("full_tag",   32'(bus.issue_tag),   32'd0);
        issue(1'b1, 32'd9, 4'd0, 32'd9, 4'd0);
        tick();
        idle_inputs();
        chk("full_ignored", 32'(bus.issue_ready), 32'd0);
        cdb(4'd1, 32'h0);
        tick();
        idle_inputs();
        chk("cdb1_no_same_dispatch", 32'(bus.exe_start), 32'd0);
        chk("cdb1_free_tag",         32'(bus.issue_tag), 32'd1);
        tick();
        chk("d2_start", 32'(bus.exe_start), 32'd1);
        chk("d2_tag",   32'(bus.exe_tag),   32'd2);
        chk("d2_srcb",  bus.exe_srcb,       32'd4);
        cdb(4'd2, 32'h0);
        tick();
        idle_inputs();
        chk("cdb2_no_same_dispatch", 32'(bus.exe_start), 32'd0);
        tick();
        chk("d3_start", 32'(bus.exe_start), 32'd1);
        chk("d3_tag",   32'(bus.exe_tag),   32'd3);
        chk("d3_isadd", 32'(bus.exe_isadd), 32'd0);
        chk("d3_srca",  bus.exe_srca,       32'd5);
        cdb(4'd3, 32'h0);
        tick();
        idle_inputs();
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            seen = seen | bus.exe_start;
        end
        chk("no_extra_dispatch", 32'(seen), 32'd0);

        // A tag-0 broadcast must not touch an entry that is still waiting.
        issue(1'b1, 32'd0, 4'd7, 32'd1, 4'd0);
        tick();
        idle_inputs();
        cdb(4'd0, 32'hDEAD);
        tick();
        idle_inputs();
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            seen = seen | bus.exe_start;
        end
        chk("tag0_no_wake", 32'(seen), 32'd0);
        cdb(4'd7, 32'd2);
        tick();
        idle_inputs();
        tick();
        chk("tag0_start", 32'(bus.exe_start), 32'd1);
        chk("tag0_srca",  bus.exe_srca,       32'd2);
        chk("tag0_srcb",  bus.exe_srcb,       32'd1);
        cdb(4'd1, 32'h0);
        tick();
        idle_inputs();

        // Asynchronous reset while entry 2 has just been dispatched.
        issue(1'b1, 32'd11, 4'd0, 32'd12, 4'd0);
        tick();
        issue(1'b0, 32'd13, 4'd0, 32'd14, 4'd0);
        tick();
        idle_inputs();
        cdb(4'd1, 32'h0);
        tick();
        idle_inputs();
        tick();
        chk("pre_rst_start", 32'(bus.exe_start), 32'd1);
        chk("pre_rst_tag",   32'(bus.exe_tag),   32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("async_start", 32'(bus.exe_start),   32'd0);
        chk("async_srca",  bus.exe_srca,         32'd0);
        chk("async_srcb",  bus.exe_srcb,         32'd0);
        chk("async_etag",  32'(bus.exe_tag),     32'd0);
        chk("async_ready", 32'(bus.issue_ready), 32'd1);
        chk("async_itag",  32'(bus.issue_tag),   32'd1);
        #3;
        reset = 1'b1;
        tick();
        tick();
        chk("post_rst_start", 32'(bus.exe_start), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/add_rs.md
ADD_RS -- requirements
Module: add_rs

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 3, meaning the number of add/sub reservation-station entries (1..8).
REQ-002 The block SHALL have parameter TAG_BASE, default 1, meaning entry i owns tag TAG_BASE+i; tag 0 means "no producer".
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port issue_valid  input  1  issue request, accepted when issue_valid && issue_ready.
REQ-006 The block SHALL have port issue_isadd  input  1  1 = add, 0 = sub.
REQ-007 The block SHALL have ports issue_vj, issue_vk  input  32  operand values, meaningful when the matching q is 0.
REQ-008 The block SHALL have ports issue_qj, issue_qk  input  4  producer tags, 0 = value present.
REQ-009 The block SHALL have port issue_ready  output  1  at least one FREE entry.
REQ-010 The block SHALL have port issue_tag  output  4  tag allocated to a request accepted this cycle.
REQ-011 The block SHALL have ports cdb_valid  input  1, cdb_tag  input  4, cdb_data  input  32  common data bus broadcast.
REQ-012 The block SHALL have port exe_start  output  1  one-cycle dispatch pulse to the adder.
REQ-013 The block SHALL have ports exe_srca, exe_srcb  output  32, exe_isadd  output  1, exe_tag  output  4  dispatched operation.

Function
REQ-014 Each entry SHALL be in one of FREE, WAIT, READY, EXEC.
REQ-015 issue_ready SHALL be combinational from registered state: 1 iff any entry is FREE.
REQ-016 issue_tag SHALL equal TAG_BASE + index of the lowest-index FREE entry; 0 when none is FREE.
REQ-017 On an accepted issue the chosen entry SHALL go to READY if both operands are resolved, else to WAIT.
REQ-018 An operand counts as resolved at issue if its q is 0 or (cdb_valid && cdb_tag == q), the latter capturing cdb_data (same-cycle bypass).
REQ-019 A WAIT entry SHALL, on cdb_valid with cdb_tag equal to a pending qj/qk, capture cdb_data into that operand, clear that q, and go READY once both q are 0.
REQ-020 cdb_tag 0 SHALL never match any operand or entry.
REQ-021 An internal unit_busy flag SHALL set on dispatch and clear at the edge where cdb_valid && cdb_tag == exe_tag.
REQ-022 When !unit_busy and any entry is READY, the lowest-index READY entry SHALL be dispatched at the next edge: exe_start = 1 for that cycle, exe_srca/srcb/isadd/tag loaded, entry -> EXEC.
REQ-023 exe_start SHALL be 0 in every cycle with no dispatch; exe_srca/srcb/isadd/tag SHALL hold their last values until the next dispatch.
REQ-024 An EXEC entry SHALL go FREE at the edge where cdb_valid && cdb_tag equals its tag; the slot is issuable from the following cycle.
REQ-025 Minimum latency: issue with both operands present at edge N, exe_start high in the cycle after edge N+1.
REQ-026 An entry made READY by the CDB at edge N SHALL be dispatchable at edge N+1.
REQ-027 A dispatch SHALL NOT occur in the same cycle as the CDB completion that clears unit_busy; the earliest is the next edge.
REQ-028 Issue to a free slot and CDB capture into other entries in the same cycle SHALL both take effect.
REQ-029 issue_valid with issue_ready = 0 SHALL be ignored with no state change.

Reset
REQ-030 While reset = 0, all entries SHALL be FREE, unit_busy = 0, exe_start = 0, exe_srca = exe_srcb = 0, exe_isadd = 0, exe_tag = 0, and all stored q/v fields = 0.
REQ-031 Reset asserted mid-operation SHALL discard all entries and any in-flight dispatch immediately, without waiting for a clock edge.

Verification
REQ-032 Issue add vj=5 qj=0 vk=7 qk=0 -> issue_tag=1; exe_start pulses one cycle later with srca=5, srcb=7, isadd=1, tag=1; CDB tag 1 -> entry FREE, issue_ready=1.
REQ-033 Issue sub qj=4 vk=3 -> WAIT; CDB tag 4 data 10 -> next cycle exe_start, srca=10, srcb=3, isadd=0.
REQ-034 Issue with qk=5 while cdb_valid, cdb_tag=5, cdb_data=0x20 -> bypass captured, entry READY directly, srcb=0x20 at dispatch.
REQ-035 Fill 3 entries all ready -> issue_ready=0, extra issue ignored; dispatch order tags 1,2,3, each only the cycle after the previous tag's CDB broadcast.
REQ-036 Reset low while entry 2 is EXEC with exe_start just pulsed -> all outputs 0, issue_ready=1, issue_tag=1 immediately.
REQ-037 cdb_valid with cdb_tag=0 while entries wait on nonzero tags -> no capture, no state change.
